// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and its UART receiver.
package rv_loader_pkg;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Loader frame states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_e;

  // UART receiver bit-phase states.
  typedef enum logic [1:0] {
    URX_IDLE  = 2'd0,
    URX_START = 2'd1,
    URX_DATA  = 2'd2,
    URX_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write port: loader drives (master), memory receives (slave).
interface imem_loader_if #(
  parameter int XLEN = 32
);
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input we, input addr, input wdata);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// uart_rx: 8N1 receiver with a 2-FF input synchroniser and start-bit glitch rejection.
// rx_valid_o / frame_err_o pulse for one cycle after the stop-bit sample.
module uart_rx
  import rv_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          meta_q, sync_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;

  // Two-flop synchroniser; the line idles high.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  // Receiver state, bit timer, shifter and output pulses.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= URX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: detect start edge, confirm at half bit, sample data and stop at bit centres.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      URX_IDLE: begin
        cnt_d = '0;
        if (!sync_q) state_d = URX_START;
        else         state_d = URX_IDLE;
      end
      URX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = 3'd0;
          // Line back high at mid start bit: treat the edge as a glitch.
          if (sync_q) state_d = URX_IDLE;
          else        state_d = URX_DATA;
        end else begin
          state_d = URX_START;
        end
      end
      URX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = URX_STOP;
          else               state_d = URX_DATA;
        end else begin
          state_d = URX_DATA;
        end
      end
      URX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = URX_IDLE;
          valid_d = sync_q;
          ferr_d  = ~sync_q;
        end else begin
          state_d = URX_STOP;
        end
      end
      default: state_d = URX_IDLE;
    endcase
  end

  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign rx_data_o   = shift_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time UART program loader for instruction memory.
// Frame: SYNC, LEN lo, LEN hi, 4*LEN little-endian data bytes [, XOR checksum].
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state and XOR accumulator).
module imem_loader
  import rv_loader_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              MEM_SIZE     = 256,
  parameter int              CLKS_PER_BIT = 16,
  parameter logic [7:0]      SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter logic [XLEN-1:0] BASE_ADDR    = '0
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          rx_i,
  output logic          core_n_reset_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  imem_loader_if.master imem
);
  logic            rx_valid_s, frame_err_s, busy_s;
  logic [7:0]      rx_data_s;
  logic [15:0]     n_s;
  loader_state_e   state_q, state_d;
  logic [15:0]     len_q, len_d, idx_q, idx_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [XLEN-1:0] word_q, word_d, addr_q, addr_d, wdata_q, wdata_d;
  logic            we_q, we_d, done_q, done_d, err_q, err_d, core_q, core_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .n_reset    (n_reset),
    .rx_i       (rx_i),
    .rx_valid_o (rx_valid_s),
    .rx_data_o  (rx_data_s),
    .frame_err_o(frame_err_s)
  );

  assign busy_s = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                  (state_q == DATA)   || (state_q == CSUM);

  // Loader state, word assembler and registered write port / status outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      len_q   <= 16'h0000;
      idx_q   <= 16'h0000;
      bcnt_q  <= 2'd0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      core_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      core_q  <= core_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Frame FSM: parse length, assemble words, issue writes, decide DONE/ERR.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    core_d  = core_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    n_s     = {rx_data_s, len_q[7:0]};
    if (busy_s && frame_err_s) begin
      state_d = ERR;
      err_d   = 1'b1;
      core_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (rx_valid_s && (rx_data_s == SYNC_BYTE)) begin
            state_d = LEN_LO;
            done_d  = 1'b0;
            err_d   = 1'b0;
            core_d  = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        LEN_LO: begin
          if (rx_valid_s) begin
            len_d   = {8'h00, rx_data_s};
            state_d = LEN_HI;
          end else begin
            state_d = LEN_LO;
          end
        end
        LEN_HI: begin
          if (rx_valid_s) begin
            len_d  = n_s;
            idx_d  = 16'h0000;
            bcnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_d = 8'h00;
`endif
            if (n_s == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
              done_d  = 1'b1;
              core_d  = 1'b1;
`endif
            end else if (n_s > 16'(MEM_SIZE)) begin
              state_d = ERR;
              err_d   = 1'b1;
              core_d  = 1'b0;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = LEN_HI;
          end
        end
        DATA: begin
          // The cycle after the last word's write pulse closes the data phase.
          if (idx_q == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
            done_d  = 1'b1;
            core_d  = 1'b1;
`endif
          end else if (rx_valid_s) begin
            bcnt_d = bcnt_q + 2'd1;
            word_d = {rx_data_s, word_q[XLEN-1:8]};
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q ^ rx_data_s;
`endif
            if (bcnt_q == 2'd3) begin
              we_d    = 1'b1;
              addr_d  = BASE_ADDR + XLEN'({idx_q, 2'b00});
              wdata_d = {rx_data_s, word_q[XLEN-1:8]};
              idx_d   = idx_q + 16'd1;
            end else begin
              we_d    = 1'b0;
            end
          end else begin
            state_d = DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (rx_valid_s) begin
            if (rx_data_s == csum_q) begin
              state_d = DONE;
              done_d  = 1'b1;
              core_d  = 1'b1;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
              core_d  = 1'b0;
            end
          end else begin
            state_d = CSUM;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem.we        = we_q;
  assign imem.addr      = addr_q;
  assign imem.wdata     = wdata_q;
  assign core_n_reset_o = core_q;
  assign busy_o         = busy_s;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level model plus per-cycle write/status checker.
module tb_imem_loader;
  localparam int CPB = 4;

  logic clk     = 1'b0;
  logic n_reset = 1'b0;
  logic rx      = 1'b1;
  logic core_n_reset, busy, done, err;

  imem_loader_if #(.XLEN(32)) bus ();

  imem_loader #(
    .XLEN(32), .MEM_SIZE(256), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .n_reset(n_reset), .rx_i(rx), .core_n_reset_o(core_n_reset),
    .busy_o(busy), .done_o(done), .err_o(err), .imem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim_b[$];
  logic       stim_s[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rxv_cnt = 0;
  logic       m_done, m_err, m_busy;
  logic       prev_we = 1'b0;
  logic       chk_done_next = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic s);
    stim_b.push_back(b);
    stim_s.push_back(s);
  endtask

  task automatic load_vec(input logic [127:0] v, input int n);
    stim_b.delete();
    stim_s.delete();
    for (int i = 0; i < n; i++) add(v[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic fetch(inout int p, output logic [7:0] b, output int st);
    if (p >= stim_b.size()) begin
      b = 8'h00; st = 2;
    end else begin
      b = stim_b[p]; st = stim_s[p] ? 0 : 1; p = p + 1;
    end
  endtask

  // Frame-level model: scan for SYNC, parse length, expected writes and outcome.
  task automatic model_run();
    int p, st, len;
    logic [7:0] b, lo, hi, cs;
    logic [31:0] w;
    wr_t e;
    p = 0;
    m_busy = 1'b0;
    while (p < stim_b.size()) begin
      fetch(p, b, st);
      if (st == 0 && b == 8'hA5) begin
        m_done = 1'b0; m_err = 1'b0; m_busy = 1'b1;
        cs = 8'h00; w = 32'h0; lo = 8'h00; hi = 8'h00;
        fetch(p, lo, st);
        if (st == 0) fetch(p, hi, st);
        len = int'({hi, lo});
        if (st == 0 && len > 256) st = 1;
        for (int k = 0; k < 4*len && st == 0; k++) begin
          fetch(p, b, st);
          if (st == 0) begin
            cs = cs ^ b;
            w  = {b, w[31:8]};
            if (k % 4 == 3) begin
              e.addr = 32'(4 * (k / 4));
              e.data = w;
`ifdef LOADER_CHECKSUM_EN
              e.last = 1'b0;
`else
              e.last = (k == 4*len - 1);
`endif
              exp_q.push_back(e);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        if (st == 0) begin
          fetch(p, b, st);
          if (st == 0 && b != cs) st = 1;
        end
`endif
        if (st == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
        end else if (st == 1) begin
          m_busy = 1'b0; m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_and_check(input string nm);
    @(negedge clk);
    for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], stim_s[i]);
    repeat (10) @(negedge clk);
    check({nm, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({nm, "_done"}, 32'(done), 32'(m_done));
    check({nm, "_err"},  32'(err),  32'(m_err));
    check({nm, "_busy"}, 32'(busy), 32'(m_busy));
    check({nm, "_core"}, 32'(core_n_reset), 32'(m_done));
  endtask

  // Count receiver byte strobes for the glitch check.
  always @(posedge clk) begin
    if (dut.u_rx.rx_valid_o) rxv_cnt <= rxv_cnt + 1;
  end

  // Per-cycle checker: writes against the model queue, strobe shape, status invariants.
  always @(negedge clk) begin
    wr_t e;
    if (n_reset) begin
      check("core_vs_done", 32'(core_n_reset), 32'(done));
      check("done_and_err", 32'(done & err), 32'd0);
      if (chk_done_next) begin
        check("done_after_last_write", 32'(done), 32'd1);
        check("core_after_last_write", 32'(core_n_reset), 32'd1);
      end
      chk_done_next <= 1'b0;
      if (bus.we) begin
        check("we_one_cycle", 32'(prev_we), 32'd0);
        check("we_while_busy", 32'(busy), 32'd1);
        check("done_at_write", 32'(done), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", bus.addr, bus.wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", bus.addr, e.addr);
          check("write_data", bus.wdata, e.data);
          if (e.last) chk_done_next <= 1'b1;
        end
      end
      prev_we <= bus.we;
    end else begin
      prev_we <= 1'b0;
      chk_done_next <= 1'b0;
    end
  end

  task automatic check_reset_values(input string nm);
    check({nm, "_core"},  32'(core_n_reset), 32'd0);
    check({nm, "_we"},    32'(bus.we), 32'd0);
    check({nm, "_addr"},  bus.addr, 32'h0);
    check({nm, "_wdata"}, bus.wdata, 32'h0);
    check({nm, "_busy"},  32'(busy), 32'd0);
    check({nm, "_done"},  32'(done), 32'd0);
    check({nm, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    int rxv0;
    #1;
    check_reset_values("reset");
    repeat (3) @(negedge clk);
    n_reset = 1'b1;

    // Two-word load.
    load_vec(88'hA5_02_00_13_00_00_00_93_00_10_00, 11);
    model_run();
    check("pin_w0_addr", exp_q[0].addr, 32'h0);
    check("pin_w0_data", exp_q[0].data, 32'h0000_0013);
    check("pin_w1_addr", exp_q[1].addr, 32'h4);
    check("pin_w1_data", exp_q[1].data, 32'h0010_0093);
    send_and_check("load");
    check("pin_load_done", 32'(done), 32'd1);

    // Noise bytes then a zero-length frame.
    load_vec(40'h55_FF_A5_00_00, 5);
`ifdef LOADER_CHECKSUM_EN
    add(8'h00, 1'b1);
`endif
    model_run();
    send_and_check("noise_zero_len");
    check("pin_zero_len_done", 32'(done), 32'd1);

    // Oversize length, then recovery with a valid frame.
    load_vec(24'hA5_01_01, 3);
    model_run();
    send_and_check("oversize");
    check("pin_oversize_err", 32'(err), 32'd1);
    check("pin_oversize_core", 32'(core_n_reset), 32'd0);
    load_vec(88'hA5_02_00_13_00_00_00_93_00_10_00, 11);
    model_run();
    send_and_check("reload");

    // Framing error on the second data byte.
    load_vec(32'hA5_01_00_11, 4);
    add(8'h22, 1'b0);
    model_run();
    send_and_check("framing");
    check("pin_framing_err", 32'(err), 32'd1);

    // One-clock low glitch while idle produces no byte.
    rxv0 = rxv_cnt;
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);
    check("glitch_err_kept", 32'(err), 32'd1);

    // Checksum frames (trailing byte ignored when the checksum feature is absent).
    load_vec(64'hA5_01_00_01_02_04_08_0F, 8);
    model_run();
    check("pin_csum_word", exp_q[0].data, 32'h0804_0201);
    send_and_check("csum_good");
    check("pin_csum_good_done", 32'(done), 32'd1);
    load_vec(64'hA5_01_00_01_02_04_08_0E, 8);
    model_run();
    send_and_check("csum_bad");
`ifdef LOADER_CHECKSUM_EN
    check("pin_csum_bad_err", 32'(err), 32'd1);
    check("pin_csum_bad_core", 32'(core_n_reset), 32'd0);
`else
    check("pin_csum_bad_done", 32'(done), 32'd1);
`endif

    // Asynchronous reset after two data bytes, then a full reload from idx 0.
    load_vec(40'hA5_02_00_13_00, 5);
    model_run();
    @(negedge clk);
    for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], stim_s[i]);
    check("midframe_busy", 32'(busy), 32'(m_busy));
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1 check_reset_values("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    load_vec(88'hA5_02_00_13_00_00_00_93_00_10_00, 11);
    model_run();
    send_and_check("after_reset");
    check("pin_after_reset_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
